fifo_read_serializer: RTL and testbench
=======================================

// Module: fifo_read_serializer
// PURPOSE
//  Read-side controller for the parallel circular-buffer FIFO. Pops PAR_READ-element
//  words from the FIFO when it signals valid and replays them one SIZE-bit element
//  per beat on a valid/ready stream toward the downstream datapath. Drains a
//  programmed element count per job, then pulses done.
// PARAMETERS
//  SIZE      2   width of one element, bits
//  PAR_READ  3   elements delivered per FIFO read (dout = PAR_READ*SIZE bits)
//  LEN_W     8   width of job length counter
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              async, active-high reset
//  clear      in   1              sync abort: back to IDLE, no pop
//  start      in   1              begin job (sampled in IDLE only)
//  cfg_len    in   LEN_W          elements to drain, latched on start
//  fifo_dout  in   PAR_READ*SIZE  FIFO read word, element 0 at [SIZE-1:0]
//  fifo_valid in   1              FIFO holds >= PAR_READ elements, dout stable
//  fifo_ren   out  1              pop one word at this clk edge
//  out_data   out  SIZE           current element
//  out_valid  out  1              out_data valid
//  out_ready  in   1              downstream accepts beat
//  busy       out  1              state != IDLE
//  done       out  1              one-cycle pulse at job end
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, idx=0, remaining=0, shreg=0; fifo_ren=0,
//    out_valid=0, out_data=0, busy=0, done=0. Reset mid-job discards everything.
//  - States: IDLE, FETCH, SHIFT, DONE.
//  - IDLE: start=1 latches remaining=cfg_len; cfg_len==0 -> DONE, else -> FETCH.
//  - FETCH: fifo_ren = (state==FETCH) & fifo_valid & ~clear (combinational).
//    On that edge shreg<=fifo_dout, idx<=0, -> SHIFT. fifo_valid=0: wait, no pop.
//  - SHIFT: out_valid=1, out_data=shreg[idx*SIZE +: SIZE]. Beat on
//    out_valid&out_ready: remaining-=1, idx+=1. If remaining becomes 0 -> DONE;
//    else if idx was PAR_READ-1 -> FETCH; else stay. No beat: data held stable.
//  - DONE: done=1 for exactly one cycle, -> IDLE. start ignored outside IDLE.
//  - Partial last word (remaining < PAR_READ at fetch): unused elements of that
//    word are dropped; the FIFO word is consumed in full.
//  - Latency: fifo_ren edge -> out_valid next cycle. No prefetch: throughput is
//    PAR_READ beats per PAR_READ+1 cycles with out_ready held high.
//  - fifo_ren never asserts outside FETCH; at most one pop per FETCH visit.
//  - clear=1 (any state, priority over start/beats): next state IDLE,
//    out_valid=0, fifo_ren=0, no done pulse; FIFO contents untouched.
//  - rst has priority over clear. out_valid/fifo_ren/done/busy decoded from
//    registered state only (plus fifo_valid and clear for fifo_ren).
// TESTING (SIZE=2, PAR_READ=3)
//  1 Reset: rst pulse mid-SHIFT -> out_valid=0, busy=0, fifo_ren=0 immediately.
//  2 Full job: cfg_len=6, fifo_dout=6'b10_01_11 then 6'b00_10_01, valid=1,
//    ready=1 -> beats 3,1,2 then 1,2,0; exactly 2 fifo_ren pulses; done 1 cycle.
//  3 Partial: cfg_len=4 -> beats e0..e2 of word0, e0 of word1, 2 pops, then done.
//  4 Backpressure: out_ready toggles 1/0 -> out_data stable while ready=0, no
//    extra pops, beat order unchanged.
//  5 Starved FIFO: fifo_valid=0 for 5 cycles in FETCH -> fifo_ren=0, out_valid=0;
//    valid rises -> pop same cycle, out_valid next cycle.
//  6 clear mid-SHIFT (cfg_len=6, after 2 beats) -> IDLE next cycle, no done,
//    no ren; cfg_len=0 start -> done pulse, zero pops, zero beats.

Source files
------------

// File: rtl/fifo_read_serializer.sv
// Read-side controller for the parallel FIFO: pops PAR_READ-element words and
// replays them one SIZE-bit element per beat, draining cfg_len elements per job.
module fifo_read_serializer #(
    parameter int SIZE     = 2,
    parameter int PAR_READ = 3,
    parameter int LEN_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     start,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [PAR_READ*SIZE-1:0] fifo_dout,
    input  logic                     fifo_valid,
    output logic                     fifo_ren,
    output logic [SIZE-1:0]          out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAR_READ - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t                        state, state_nxt;
    logic [PAR_READ-1:0][SIZE-1:0] shreg, shreg_nxt;
    logic [IDX_W-1:0]              idx, idx_nxt;
    logic [LEN_W-1:0]              remaining, rem_nxt;
    logic                          beat;

    // All handshake outputs decode from registered state; clear only gates the pop.
    assign fifo_ren  = (state == FETCH) & fifo_valid & ~clear;
    assign out_valid = (state == SHIFT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_data  = out_valid ? shreg[idx] : '0;
    assign beat      = out_valid & out_ready & ~clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            idx       <= idx_nxt;
            remaining <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        rem_nxt   = remaining;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rem_nxt   = cfg_len;
                        state_nxt = (cfg_len == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (fifo_ren) begin
                        shreg_nxt = fifo_dout;
                        idx_nxt   = '0;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        rem_nxt = remaining - 1'b1;
                        idx_nxt = idx + 1'b1;
                        // Tail elements of a partial last word are simply never replayed.
                        if (remaining == LEN_W'(1))
                            state_nxt = DONE;
                        else if (idx == IDX_LAST)
                            state_nxt = FETCH;
                    end
                end
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Scoreboard bench for fifo_read_serializer: a queue-backed FIFO model feeds the
// DUT, expected elements are queued per job and popped on every accepted beat.
module tb_fifo_read_serializer;
    localparam int SIZE = 2;
    localparam int PR   = 3;
    localparam int LW   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic [LW-1:0]     cfg_len = '0;
    logic [PR*SIZE-1:0] fifo_dout = '0;
    logic              fifo_valid = 1'b0;
    logic              fifo_ren;
    logic [SIZE-1:0]   out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              done;

    fifo_read_serializer #(.SIZE(SIZE), .PAR_READ(PR), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .cfg_len(cfg_len),
        .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .fifo_ren(fifo_ren),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [PR*SIZE-1:0] fq[$];
    int                 eq[$];
    int                 pops = 0, beats = 0, dones = 0;
    bit                 fen = 1'b1, bp = 1'b0;
    bit                 ren_s = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
    logic [SIZE-1:0]    prev_data = '0;

    // Monitor: sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        ren_s = fifo_ren;
        if (!rst) begin
            if (fifo_ren) begin
                chk("ren_valid", 32'(fifo_valid), 32'd1);
                chk("ren_state", {30'd0, busy, out_valid}, 32'd2);
            end
            if (prev_stall)
                chk("hold", {29'd0, out_valid, out_data}, {29'd0, 1'b1, prev_data});
            if (out_valid && out_ready && !clear) begin
                beats++;
                if (eq.size() == 0) chk("beat_extra", 32'd1, 32'd0);
                else chk("beat", 32'(out_data), 32'(eq.pop_front()));
            end
            if (done) begin
                dones++;
                chk("done_1cyc", 32'(prev_done), 32'd0);
            end
            prev_stall = out_valid && !out_ready && !clear;
            prev_data  = out_data;
            prev_done  = done;
        end else begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end
    end

    // FIFO model and out_ready driver, updated just after the active edge.
    always @(posedge clk) begin
        #1;
        if (ren_s && !rst) begin
            if (fq.size() > 0) void'(fq.pop_front());
            pops++;
        end
        ren_s      = 1'b0;
        fifo_valid = fen && (fq.size() > 0);
        fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
        out_ready  = bp ? ~out_ready : 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_job(input int len, input int nw, input logic [5:0] w0, input logic [5:0] w1);
        logic [5:0] w;
        fq.push_back(w0);
        if (nw > 1) fq.push_back(w1);
        for (int i = 0; i < len; i++) begin
            w = (i < PR) ? w0 : w1;
            eq.push_back(int'((w >> (SIZE * (i % PR))) & 6'h3));
        end
    endtask

    task automatic kick(input int len);
        cfg_len = LW'(len);
        start   = 1'b1;
        cyc(1);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0 = dones;
        int n  = 0;
        while (dones == d0 && n < 300) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(dones != d0), 32'd1);
    endtask

    int p0, b0, d0, n;

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ren", 32'(fifo_ren), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Full two-word job: beats 3,1,2 then 1,2,0
        p0 = pops;
        push_job(6, 2, 6'b10_01_11, 6'b00_10_01);
        kick(6);
        wait_done("full_done");
        chk("full_pops", 32'(pops - p0), 32'd2);
        chk("full_left", 32'(eq.size()), 32'd0);
        cyc(1);
        chk("full_idle", 32'(busy), 32'd0);

        // Partial last word: second word consumed though only e0 used
        p0 = pops;
        push_job(4, 2, 6'b01_00_10, 6'b11_11_01);
        kick(4);
        wait_done("part_done");
        chk("part_pops", 32'(pops - p0), 32'd2);
        chk("part_left", 32'(eq.size()), 32'd0);
        chk("part_fifo", 32'(fq.size()), 32'd0);

        // Backpressure: out_ready toggles
        p0 = pops;
        bp = 1'b1;
        push_job(6, 2, 6'b11_00_01, 6'b10_11_00);
        kick(6);
        wait_done("bp_done");
        bp = 1'b0;
        chk("bp_pops", 32'(pops - p0), 32'd2);
        chk("bp_left", 32'(eq.size()), 32'd0);
        cyc(2);

        // Starved FIFO
        fen = 1'b0;
        p0 = pops;
        push_job(3, 1, 6'b01_10_11, 6'b0);
        kick(3);
        repeat (5) begin
            @(negedge clk);
            chk("starve_ren", 32'(fifo_ren), 32'd0);
            chk("starve_valid", 32'(out_valid), 32'd0);
            chk("starve_busy", 32'(busy), 32'd1);
        end
        fen = 1'b1;
        @(negedge clk);
        chk("wake_ren", 32'(fifo_ren), 32'd1);
        chk("wake_valid0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("wake_valid1", 32'(out_valid), 32'd1);
        wait_done("starve_done");
        chk("starve_pops", 32'(pops - p0), 32'd1);
        cyc(1);

        // clear mid-SHIFT after two beats
        p0 = pops;
        b0 = beats;
        push_job(2, 2, 6'b10_01_11, 6'b00_10_01);
        kick(6);
        n = 0;
        while (beats < b0 + 2 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("clr_reach", 32'(beats - b0), 32'd2);
        d0 = dones;
        clear = 1'b1;
        cyc(1);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_ren", 32'(fifo_ren), 32'd0);
        clear = 1'b0;
        cyc(5);
        chk("clr_nodone", 32'(dones - d0), 32'd0);
        chk("clr_pops", 32'(pops - p0), 32'd1);
        chk("clr_fifo", 32'(fq.size()), 32'd1);
        chk("clr_left", 32'(eq.size()), 32'd0);
        fq.delete();
        cyc(1);

        // Zero-length job
        p0 = pops;
        b0 = beats;
        kick(0);
        wait_done("zero_done");
        chk("zero_pops", 32'(pops - p0), 32'd0);
        chk("zero_beats", 32'(beats - b0), 32'd0);
        cyc(1);

        // Async reset mid-SHIFT
        push_job(6, 2, 6'b10_01_11, 6'b00_10_01);
        kick(6);
        n = 0;
        while (!out_valid && n < 50) begin
            cyc(1);
            n++;
        end
        chk("rst_reach", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ren", 32'(fifo_ren), 32'd0);
        cyc(1);
        rst = 1'b0;
        fq.delete();
        eq.delete();
        cyc(2);
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
